// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_pkg
//  Description : Shared constants and helpers for the fixed-point multiplier.
//  Revision    : 1.0 - initial pipelined release
// ============================================================================
package fxp_pkg;

  localparam int W_DEFAULT    = 12;
  localparam int FRAC_DEFAULT = 4;

  localparam logic ROUND_TRUNC   = 1'b0;
  localparam logic ROUND_HALF_UP = 1'b1;

  // Largest unsigned value representable in w bits (w <= 32).
  function automatic logic [31:0] fxp_max(input int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_mult_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_mult_pipe_if
//  Description : Operand/result handshake bundle of the fixed-point multiplier.
//  Revision    : 1.0 - initial pipelined release
// ============================================================================
interface fxp_mult_pipe_if #(
  parameter int W     = 12,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_round;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_p;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_round, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_round, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_ovf, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/fxp_mult_core.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_mult_core
//  Description : Combinational unsigned fixed-point multiply, round, overflow.
//                FXP_MULT_SAT_EN selects saturation on overflow (else wrap).
//  Revision    : 1.0 - initial pipelined release
// ============================================================================
module fxp_mult_core
  import fxp_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         round,
  output logic [W-1:0] p,
  output logic         ovf
);

  logic [2*W-1:0] w_a_ext;
  logic [2*W-1:0] w_b_ext;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_rnd;
  logic [2*W-1:0] w_r;

  assign w_a_ext = {{W{1'b0}}, a};
  assign w_b_ext = {{W{1'b0}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  // The rounded product always fits in 2W bits, so no carry is lost here.
  generate
    if (FRAC > 0) begin : g_round
      localparam logic [2*W-1:0] c_half = {{(2*W-1){1'b0}}, 1'b1} << (FRAC - 1);
      assign w_prod_rnd = w_prod + ((round == ROUND_HALF_UP) ? c_half : '0);
    end else begin : g_no_round
      assign w_prod_rnd = w_prod;
    end
  endgenerate

  assign w_r = w_prod_rnd >> FRAC;
  assign ovf = |w_r[2*W-1:W];

`ifdef FXP_MULT_SAT_EN
  assign p = ovf ? W'(fxp_max(W)) : w_r[W-1:0];
`else
  assign p = w_r[W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/fxp_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_mult_pipe
//  Description : Elastic pipelined fixed-point multiplier with tag pass-through
//                and saturating overflow counter. Build option FXP_MULT_SAT_EN.
//  Revision    : 1.0 - initial pipelined release
// ============================================================================
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int FRAC   = FRAC_DEFAULT,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fxp_mult_pipe_if.slave   bus,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [W-1:0]      w_core_p;
  logic              w_core_ovf;
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_load;
  logic              w_out_xfer;
  logic [CNT_W-1:0]  r_ovf_cnt;

  fxp_mult_core #(
    .W    (W),
    .FRAC (FRAC)
  ) u_core (
    .a     (bus.in_a),
    .b     (bus.in_b),
    .round (bus.in_round),
    .p     (w_core_p),
    .ovf   (w_core_ovf)
  );

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    logic l_acc;
    l_acc  = bus.out_ready;
    w_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      l_acc     = ~w_v[k] | l_acc;
      w_load[k] = l_acc;
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             r_v;
      logic [W-1:0]     r_p;
      logic             r_ovf;
      logic [TAG_W-1:0] r_tag;
      logic             w_src_v;
      logic [W-1:0]     w_src_p;
      logic             w_src_ovf;
      logic [TAG_W-1:0] w_src_tag;

      if (k == 0) begin : g_head
        assign w_src_v   = bus.in_valid;
        assign w_src_p   = w_core_p;
        assign w_src_ovf = w_core_ovf;
        assign w_src_tag = bus.in_tag;
      end else begin : g_body
        assign w_src_v   = g_stage[k-1].r_v;
        assign w_src_p   = g_stage[k-1].r_p;
        assign w_src_ovf = g_stage[k-1].r_ovf;
        assign w_src_tag = g_stage[k-1].r_tag;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v   <= 1'b0;
          r_p   <= '0;
          r_ovf <= 1'b0;
          r_tag <= '0;
        end else if (w_load[k]) begin
          r_v <= w_src_v;
          if (w_src_v) begin
            r_p   <= w_src_p;
            r_ovf <= w_src_ovf;
            r_tag <= w_src_tag;
          end
        end
      end

      assign w_v[k] = r_v;
    end
  endgenerate

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = g_stage[STAGES-1].r_v;
  assign bus.out_p     = g_stage[STAGES-1].r_p;
  assign bus.out_ovf   = g_stage[STAGES-1].r_ovf;
  assign bus.out_tag   = g_stage[STAGES-1].r_tag;

  assign w_out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_out_xfer && bus.out_ovf && (r_ovf_cnt != c_cnt_max)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;

endmodule
`default_nettype wire
